// File: rtl/dct_frame_arb.sv
// Two-requester frame arbiter feeding the vector-rotation RAM sink.
// A frame is owned until the sink reports completion on done_in; frame-length and size faults are flagged.
module dct_frame_arb #(
    parameter int wData = 28
) (
    input  logic             clk,
    input  logic             rst_sync,
    input  logic             s0_valid,
    input  logic             s0_sop,
    input  logic             s0_eop,
    output logic             s0_ready,
    input  logic [wData-1:0] s0_real,
    input  logic [wData-1:0] s0_imag,
    input  logic [11:0]      s0_fftpts,
    input  logic             s1_valid,
    input  logic             s1_sop,
    input  logic             s1_eop,
    output logic             s1_ready,
    input  logic [wData-1:0] s1_real,
    input  logic [wData-1:0] s1_imag,
    input  logic [11:0]      s1_fftpts,
    output logic             m_valid,
    output logic             m_sop,
    output logic             m_eop,
    output logic [wData-1:0] m_real,
    output logic [wData-1:0] m_imag,
    output logic [11:0]      m_fftpts,
    input  logic             m_ready,
    input  logic             done_in,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             len_err,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PASS      = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_grant, w_grant_nxt;
    logic        r_last, w_last_nxt;
    logic [11:0] r_beat, w_beat_nxt;
    logic [11:0] r_fftpts, w_fftpts_nxt;
    logic        r_cfg_drain, w_cfg_drain_nxt;
    logic        r_len_err, w_len_err_nxt;
    logic        r_cfg_err, w_cfg_err_nxt;

    logic             w_cand0, w_cand1, w_pick1;
    logic [11:0]      w_pick_fftpts;
    logic             w_sel;
    logic             w_sel_valid, w_sel_sop, w_sel_eop;
    logic [wData-1:0] w_sel_real, w_sel_imag;
    logic             w_first, w_last, w_xfer;
    logic             w_s0_ready, w_s1_ready, w_m_valid, w_m_sop, w_m_eop;
    logic [wData-1:0] w_m_real, w_m_imag;

    // Legal frame sizes are the powers of two from 8 to 2048.
    function automatic logic f_size_ok(input logic [11:0] n);
        f_size_ok = (n >= 12'd8) && ((n & (n - 12'd1)) == 12'd0);
    endfunction

    assign w_cand0       = s0_valid && s0_sop;
    assign w_cand1       = s1_valid && s1_sop;
    // r_last holds the index granted last; on a tie the other requester wins.
    assign w_pick1       = w_cand1 && (!w_cand0 || (r_last == 1'b0));
    assign w_pick_fftpts = w_pick1 ? s1_fftpts : s0_fftpts;

    assign w_sel       = r_grant[1];
    assign w_sel_valid = w_sel ? s1_valid : s0_valid;
    assign w_sel_sop   = w_sel ? s1_sop   : s0_sop;
    assign w_sel_eop   = w_sel ? s1_eop   : s0_eop;
    assign w_sel_real  = w_sel ? s1_real  : s0_real;
    assign w_sel_imag  = w_sel ? s1_imag  : s0_imag;
    assign w_first     = (r_beat == 12'd0);
    assign w_last      = ((r_beat + 12'd1) == r_fftpts);
    assign w_xfer      = w_sel_valid && m_ready;

    // Next-state, handshake and datapath selection.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_last_nxt      = r_last;
        w_beat_nxt      = r_beat;
        w_fftpts_nxt    = r_fftpts;
        w_cfg_drain_nxt = r_cfg_drain;
        w_len_err_nxt   = 1'b0;
        w_cfg_err_nxt   = 1'b0;
        w_s0_ready      = 1'b0;
        w_s1_ready      = 1'b0;
        w_m_valid       = 1'b0;
        w_m_sop         = 1'b0;
        w_m_eop         = 1'b0;
        w_m_real        = {wData{1'b0}};
        w_m_imag        = {wData{1'b0}};
        case (r_state)
            ST_IDLE: begin
                w_s0_ready = s0_valid && !s0_sop;
                w_s1_ready = s1_valid && !s1_sop;
                if (w_cand0 || w_cand1) begin
                    w_grant_nxt  = w_pick1 ? 2'b10 : 2'b01;
                    w_fftpts_nxt = w_pick_fftpts;
                    w_beat_nxt   = 12'd0;
                    if (f_size_ok(w_pick_fftpts)) begin
                        w_state_nxt     = ST_PASS;
                        w_cfg_drain_nxt = 1'b0;
                    end else begin
                        w_state_nxt     = ST_DRAIN;
                        w_cfg_drain_nxt = 1'b1;
                        w_cfg_err_nxt   = 1'b1;
                    end
                end else begin
                    w_grant_nxt = 2'b00;
                end
            end
            ST_PASS: begin
                w_m_valid  = w_sel_valid;
                w_m_sop    = w_sel_valid && w_first;
                w_m_eop    = w_sel_valid && (w_sel_eop || w_last);
                w_m_real   = w_sel_real;
                w_m_imag   = w_sel_imag;
                w_s0_ready = !w_sel && m_ready;
                w_s1_ready = w_sel && m_ready;
                if (w_xfer) begin
                    w_beat_nxt    = r_beat + 12'd1;
                    w_len_err_nxt = w_sel_sop && !w_first;
                    if (w_sel_eop) begin
                        w_state_nxt = ST_WAIT_DONE;
                        if (!w_last) begin
                            w_len_err_nxt = 1'b1;
                        end else begin
                            w_len_err_nxt = w_sel_sop && !w_first;
                        end
                    end else if (w_last) begin
                        // Frame overran N: close it at N and swallow the remainder.
                        w_state_nxt   = ST_DRAIN;
                        w_len_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_PASS;
                    end
                end else begin
                    w_beat_nxt = r_beat;
                end
            end
            ST_DRAIN: begin
                w_s0_ready = !w_sel;
                w_s1_ready = w_sel;
                if (w_sel_valid && w_sel_eop) begin
                    if (r_cfg_drain) begin
                        w_state_nxt     = ST_IDLE;
                        w_grant_nxt     = 2'b00;
                        w_cfg_drain_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_WAIT_DONE;
                    end
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_WAIT_DONE: begin
                if (done_in) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                    w_last_nxt  = r_grant[1];
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_state     <= ST_IDLE;
            r_grant     <= 2'b00;
            r_last      <= 1'b1;
            r_beat      <= 12'd0;
            r_fftpts    <= 12'd0;
            r_cfg_drain <= 1'b0;
            r_len_err   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_last      <= w_last_nxt;
            r_beat      <= w_beat_nxt;
            r_fftpts    <= w_fftpts_nxt;
            r_cfg_drain <= w_cfg_drain_nxt;
            r_len_err   <= w_len_err_nxt;
            r_cfg_err   <= w_cfg_err_nxt;
        end
    end

    // Combinational handshakes are held low during reset so nothing moves mid-reset.
    assign s0_ready = w_s0_ready && !rst_sync;
    assign s1_ready = w_s1_ready && !rst_sync;
    assign m_valid  = w_m_valid && !rst_sync;
    assign m_sop    = w_m_sop && !rst_sync;
    assign m_eop    = w_m_eop && !rst_sync;
    assign m_real   = w_m_real;
    assign m_imag   = w_m_imag;
    assign m_fftpts = r_fftpts;
    assign grant    = r_grant;
    assign busy     = (r_state != ST_IDLE);
    assign len_err  = r_len_err;
    assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_dct_frame_arb.sv
// Randomized frame-level bench for dct_frame_arb with a transaction scoreboard.
module tb_dct_frame_arb;
    localparam int W = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_sync, done_in, m_ready;
    logic s_valid [2];
    logic s_sop [2];
    logic s_eop [2];
    logic [W-1:0] s_real [2];
    logic [W-1:0] s_imag [2];
    logic [11:0] s_fftpts [2];
    logic s0_ready, s1_ready;
    logic m_valid, m_sop, m_eop, busy, len_err, cfg_err;
    logic [W-1:0] m_real, m_imag;
    logic [11:0] m_fftpts;
    logic [1:0] grant;

    dct_frame_arb #(.wData(W)) dut (
        .clk(clk), .rst_sync(rst_sync),
        .s0_valid(s_valid[0]), .s0_sop(s_sop[0]), .s0_eop(s_eop[0]), .s0_ready(s0_ready),
        .s0_real(s_real[0]), .s0_imag(s_imag[0]), .s0_fftpts(s_fftpts[0]),
        .s1_valid(s_valid[1]), .s1_sop(s_sop[1]), .s1_eop(s_eop[1]), .s1_ready(s1_ready),
        .s1_real(s_real[1]), .s1_imag(s_imag[1]), .s1_fftpts(s_fftpts[1]),
        .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_real(m_real), .m_imag(m_imag),
        .m_fftpts(m_fftpts), .m_ready(m_ready), .done_in(done_in),
        .grant(grant), .busy(busy), .len_err(len_err), .cfg_err(cfg_err)
    );

    typedef struct packed {
        logic [1:0]   g;
        logic         sop;
        logic         eop;
        logic [W-1:0] re;
        logic [W-1:0] im;
    } beat_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t mq[$];
    int    len_cnt = 0;
    int    cfg_cnt = 0;
    int    mq_base, len_base, cfg_base;
    int    order[$];
    bit    model_last;
    bit    m_rand;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit size_ok(input int n);
        for (int e = 3; e <= 11; e++) begin
            if (n == (1 << e)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic rdy(input int k);
        return (k == 0) ? s0_ready : s1_ready;
    endfunction

    // Sink side: record every transfer and every error-pulse cycle.
    always @(negedge clk) begin
        if (rst_sync === 1'b0) begin
            if (m_valid && m_ready) mq.push_back('{grant, m_sop, m_eop, m_real, m_imag});
            if (len_err) len_cnt++;
            if (cfg_err) cfg_cnt++;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = m_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic sync_bases();
        mq_base  = mq.size();
        len_base = len_cnt;
        cfg_base = cfg_cnt;
    endtask

    task automatic send_frame(input int k, input int n, input int len, input bit inj);
        logic [W-1:0] re[$];
        logic [W-1:0] im[$];
        bit sp[$];
        int sent, cyc, nx, exp_len;
        bit x, good;
        logic [1:0] g;
        sent = 0; cyc = 0; exp_len = 0;
        good = size_ok(n);
        g = (k == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < len; i++) begin
            re.push_back(W'($urandom));
            im.push_back(W'($urandom));
            sp.push_back((i == 0) || (inj && ($urandom_range(0, 5) == 0)));
        end
        s_fftpts[k] = n[11:0];
        while (sent < len && cyc < 6000) begin
            s_valid[k] = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            s_sop[k]   = sp[sent];
            s_eop[k]   = (sent == len - 1);
            s_real[k]  = re[sent];
            s_imag[k]  = im[sent];
            @(negedge clk);
            x = s_valid[k] && rdy(k);
            @(posedge clk);
            #1;
            cyc++;
            if (x) sent++;
        end
        s_valid[k] = 1'b0; s_sop[k] = 1'b0; s_eop[k] = 1'b0;
        if (sent < len) chk("drv_timeout", 64'(sent), 64'(len));
        if (good) begin
            nx = (len < n) ? len : n;
            for (int i = 0; i < nx; i++) begin
                if ((i > 0 && sp[i]) || (i == nx - 1 && len != n)) exp_len++;
            end
            repeat ($urandom_range(2, 4)) begin
                @(negedge clk);
                chk("wait_busy", 64'(busy), 64'd1);
                chk("wait_rdy", 64'(rdy(k)), 64'd0);
                chk("wait_mvalid", 64'(m_valid), 64'd0);
            end
            chk("nxfer", 64'(mq.size() - mq_base), 64'(nx));
            for (int i = 0; i < nx; i++) begin
                if (mq_base + i < mq.size())
                    chk("beat", 64'(mq[mq_base + i]), 64'(beat_t'{g, i == 0, i == nx - 1, re[i], im[i]}));
            end
            chk("len_err", 64'(len_cnt - len_base), 64'(exp_len));
            chk("cfg_err", 64'(cfg_cnt - cfg_base), 64'd0);
            chk("fftpts", 64'(m_fftpts), 64'(n[11:0]));
            @(posedge clk); #1; done_in = 1'b1;
            @(posedge clk); #1; done_in = 1'b0;
            sync_bases();
            model_last = (k == 1);
            order.push_back(k);
            @(negedge clk);
            chk("done_idle", 64'(busy), 64'd0);
            chk("done_grant", 64'(grant), 64'd0);
        end else begin
            @(negedge clk);
            chk("cfg_idle", 64'(busy), 64'd0);
            chk("cfg_nxfer", 64'(mq.size() - mq_base), 64'd0);
            chk("cfg_pulse", 64'(cfg_cnt - cfg_base), 64'd1);
            chk("cfg_len", 64'(len_cnt - len_base), 64'd0);
            chk("cfg_fftpts", 64'(m_fftpts), 64'(n[11:0]));
            sync_bases();
            order.push_back(k);
        end
    endtask

    task automatic tie_test(input int n);
        int first_exp, ob;
        first_exp = model_last ? 0 : 1;
        ob = order.size();
        fork
            send_frame(0, n, n, 1'b0);
            send_frame(1, n, n, 1'b0);
        join
        chk("tie_first", 64'(order[ob]), 64'(first_exp));
        chk("tie_second", 64'(order[ob + 1]), 64'(1 - first_exp));
    endtask

    initial begin
        int nb, cyc, k, n, len;
        bit x;
        int sizes[9] = '{8, 16, 32, 64, 128, 24, 100, 4, 0};
        rst_sync = 1'b1; done_in = 1'b0; m_rand = 1'b0; model_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0; s_sop[i] = 1'b0; s_eop[i] = 1'b0;
            s_real[i] = '0; s_imag[i] = '0; s_fftpts[i] = 12'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        s_valid[0] = 1'b1;
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fftpts", 64'(m_fftpts), 64'd0);
        chk("rst_errs", 64'({len_err, cfg_err}), 64'd0);
        chk("rst_ready", 64'({s0_ready, s1_ready, m_valid}), 64'd0);
        @(posedge clk); #1;
        rst_sync = 1'b0; s_valid[0] = 1'b0;
        sync_bases();

        s_valid[1] = 1'b1;
        @(negedge clk);
        chk("idle_discard", 64'(s1_ready), 64'd1);
        @(posedge clk); #1;
        s_valid[1] = 1'b0;
        done_in = 1'b1;
        @(posedge clk); #1;
        done_in = 1'b0;
        @(negedge clk);
        chk("stray_done", 64'(busy), 64'd0);
        @(posedge clk); #1;

        tie_test(16);
        tie_test(16);
        send_frame(0, 512, 512, 1'b0);
        send_frame(1, 512, 100, 1'b0);
        send_frame(0, 16, 20, 1'b0);
        send_frame(0, 300, 10, 1'b0);

        // Reset in the middle of a frame with the sink throttling.
        m_rand = 1'b1;
        s_fftpts[0] = 12'd512; s_valid[0] = 1'b1; s_sop[0] = 1'b1; s_eop[0] = 1'b0;
        nb = 0; cyc = 0;
        while (nb < 200 && cyc < 3000) begin
            s_real[0] = W'($urandom);
            @(negedge clk);
            x = s_valid[0] && s0_ready;
            @(posedge clk); #1;
            cyc++;
            if (x) begin
                nb++;
                s_sop[0] = 1'b0;
            end
        end
        chk("rst_reach", 64'(nb), 64'd200);
        rst_sync = 1'b1;
        @(negedge clk);
        chk("midrst_hs", 64'({s0_ready, s1_ready, m_valid}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_grant", 64'(grant), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_fftpts", 64'(m_fftpts), 64'd0);
        chk("midrst_errs", 64'({len_err, cfg_err}), 64'd0);
        @(posedge clk); #1;
        rst_sync = 1'b0; s_valid[0] = 1'b0;
        model_last = 1'b1;
        sync_bases();
        send_frame(0, 64, 64, 1'b0);

        for (int t = 0; t < 14; t++) begin
            k = int'($urandom_range(0, 1));
            n = sizes[$urandom_range(0, 8)];
            len = size_ok(n) ? int'($urandom_range(n - 4, n + 6)) : int'($urandom_range(1, 20));
            send_frame(k, n, len, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dct_frame_arb.md
DCT_FRAME_ARB -- requirements
Module: dct_frame_arb

Interface
REQ-001 Parameter: wData, default 28, width of each real/imag sample.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_sync  in  1  synchronous reset, active-high.
REQ-005 sK_valid, sK_sop, sK_eop (K=0,1)  in  1 each  requester K stream controls.
REQ-006 sK_ready (K=0,1)  out  1  requester K ready.
REQ-007 sK_real, sK_imag (K=0,1)  in  wData each  requester K sample.
REQ-008 sK_fftpts (K=0,1)  in  12  requester K frame size N.
REQ-009 m_valid, m_sop, m_eop  out  1 each  stream controls into the vector-rotation RAM sink.
REQ-010 m_real, m_imag  out  wData each  forwarded sample.
REQ-011 m_fftpts  out  12  latched N of the current frame.
REQ-012 m_ready  in  1  sink_ready of the vector-rotation RAM.
REQ-013 done_in  in  1  source_eop pulse of the vector-rotation RAM.
REQ-014 grant  out  2  one-hot owner; 00 when idle.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 len_err, cfg_err  out  1 each  single-cycle error pulses.

Function
REQ-017 The FSM SHALL have four states: IDLE, PASS, DRAIN and WAIT_DONE.
REQ-018 IDLE SHALL treat requester K as a candidate when sK_valid&&sK_sop; sK_ready SHALL be 0 for candidates and 1 for non-candidates presenting valid without sop, whose beats are discarded.
REQ-019 If both requesters are candidates, the one not granted last SHALL win; after reset requester 0 has priority.
REQ-020 On a win, the block SHALL register grant and latch sK_fftpts into m_fftpts, then move to PASS; first transfer is possible 1 cycle after sop is presented.
REQ-021 If the latched N is not a power of two in 8..2048, the block SHALL pulse cfg_err, enter DRAIN and forward nothing.
REQ-022 In PASS, datapath is combinational: m_valid=sK_valid, sK_ready=m_ready, m_real/m_imag=sK data; a transfer is valid&&ready.
REQ-023 m_sop SHALL be 1 only on the first beat of the frame; a requester sop on a later beat SHALL be masked and pulse len_err.
REQ-024 A 12-bit beat counter SHALL clear at grant and increment per transfer.
REQ-025 If eop transfers at beat count c (0-based) with c+1≠N, len_err SHALL pulse; in either case the state SHALL move to WAIT_DONE.
REQ-026 If beat c+1==N transfers without sK_eop, m_eop SHALL be forced to 1, len_err SHALL pulse, and the state SHALL move to DRAIN.
REQ-027 In DRAIN, sK_ready=1 and m_valid=0; the eop beat SHALL move the state to WAIT_DONE after a frame overrun, or to IDLE after a cfg_err.
REQ-028 WAIT_DONE SHALL hold all sK_ready=0 and m_valid=0 until done_in=1, then go to IDLE and update last-granted.
REQ-029 done_in outside WAIT_DONE SHALL be ignored.
REQ-030 The non-granted requester's ready SHALL be 0 in every state except the IDLE discard case.

Reset
REQ-031 While rst_sync=1, state SHALL go to IDLE and the following SHALL be 0: grant, busy, len_err, cfg_err, beat counter, m_fftpts, all sK_ready and m_valid; priority SHALL return to requester 0.
REQ-032 Reset SHALL take effect mid-frame without completing or flushing the frame.

Verification
REQ-033 s0 sends an N=512 frame of 512 beats with eop on beat 511 and m_ready=1 -> 512 m transfers, m_sop on beat 0, m_eop on beat 511, no errors, WAIT_DONE until done_in, then IDLE.
REQ-034 s0 and s1 assert sop in the same cycle after reset -> grant=01; after done_in, s1 gets grant=10; on a repeat tie, s0 wins.
REQ-035 s1 sends N=512 with eop on beat 99 -> m_eop on beat 99, len_err pulse, then WAIT_DONE.
REQ-036 s0 sends N=16 with 20 beats -> m_eop forced on beat 15, len_err pulse, beats 16..19 drained with m_valid=0.
REQ-037 s0 sends N=300 -> cfg_err pulse, no m_valid, frame drained, IDLE.
REQ-038 rst_sync is asserted at beat 200 of a frame with m_ready toggling -> next cycle all outputs are 0 and state is IDLE; a new sop is accepted normally.
